// File: rtl/universal_reg.sv
// Multi-mode register: hold, load, inc/dec (wrap or saturate), shift and rotate,
// with registered carry/shift-out, zero and saturation flags.
module universal_reg #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit              SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             zero,
  output logic             sat
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_INC  = 3'b010,
    MODE_DEC  = 3'b011,
    MODE_SHL  = 3'b100,
    MODE_SHR  = 3'b101,
    MODE_ROTL = 3'b110,
    MODE_ROTR = 3'b111
  } mode_t;

  logic [WIDTH-1:0] r_out;
  logic             r_co;
  logic             r_zero;
  logic             r_sat;

  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_co_nxt;
  logic             w_sat_nxt;

  // Bit WIDTH of the extended sum/difference is the carry or borrow.
  assign w_inc = {1'b0, r_out} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, r_out} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_out_nxt = r_out;
    w_co_nxt  = r_co;
    w_sat_nxt = r_sat;
    case (mode_t'(mode))
      MODE_HOLD: begin
        w_out_nxt = r_out;
      end
      MODE_LOAD: begin
        w_out_nxt = in;
        w_co_nxt  = 1'b0;
        w_sat_nxt = 1'b0;
      end
      MODE_INC: begin
        w_co_nxt = w_inc[WIDTH];
        if (SATURATE && w_inc[WIDTH]) begin
          w_out_nxt = r_out;
          w_sat_nxt = 1'b1;
        end else begin
          w_out_nxt = w_inc[WIDTH-1:0];
          w_sat_nxt = 1'b0;
        end
      end
      MODE_DEC: begin
        w_co_nxt = w_dec[WIDTH];
        if (SATURATE && w_dec[WIDTH]) begin
          w_out_nxt = r_out;
          w_sat_nxt = 1'b1;
        end else begin
          w_out_nxt = w_dec[WIDTH-1:0];
          w_sat_nxt = 1'b0;
        end
      end
      MODE_SHL: begin
        w_out_nxt = {r_out[WIDTH-2:0], ser_in};
        w_co_nxt  = r_out[WIDTH-1];
        w_sat_nxt = 1'b0;
      end
      MODE_SHR: begin
        w_out_nxt = {ser_in, r_out[WIDTH-1:1]};
        w_co_nxt  = r_out[0];
        w_sat_nxt = 1'b0;
      end
      MODE_ROTL: begin
        w_out_nxt = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
        w_co_nxt  = r_out[WIDTH-1];
        w_sat_nxt = 1'b0;
      end
      MODE_ROTR: begin
        w_out_nxt = {r_out[0], r_out[WIDTH-1:1]};
        w_co_nxt  = r_out[0];
        w_sat_nxt = 1'b0;
      end
      default: begin
        w_out_nxt = r_out;
      end
    endcase
  end

  // zero is registered from the same next value as out so both agree every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= RESET_VALUE;
      r_co   <= 1'b0;
      r_sat  <= 1'b0;
      r_zero <= (RESET_VALUE == '0);
    end else if (clr) begin
      r_out  <= RESET_VALUE;
      r_co   <= 1'b0;
      r_sat  <= 1'b0;
      r_zero <= (RESET_VALUE == '0);
    end else if (en) begin
      r_out  <= w_out_nxt;
      r_co   <= w_co_nxt;
      r_sat  <= w_sat_nxt;
      r_zero <= (w_out_nxt == '0);
    end
  end

  assign out  = r_out;
  assign co   = r_co;
  assign zero = r_zero;
  assign sat  = r_sat;

endmodule

// File: tb/tb_universal_reg.sv
// Bench for universal_reg: a wrapping and a saturating instance share stimulus;
// a behavioural model fills per-instance expected queues that are drained after each edge.
module tb_universal_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;

  logic         clk;
  logic         reset;
  logic         clr;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] in;
  logic         ser_in;

  logic [W-1:0] w0_out, w1_out;
  logic         w0_co, w1_co, w0_zero, w1_zero, w0_sat, w1_sat;

  universal_reg #(.WIDTH(W), .RESET_VALUE(RV), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode), .in(in),
    .ser_in(ser_in), .out(w0_out), .co(w0_co), .zero(w0_zero), .sat(w0_sat)
  );

  universal_reg #(.WIDTH(W), .RESET_VALUE(RV), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode), .in(in),
    .ser_in(ser_in), .out(w1_out), .co(w1_co), .zero(w1_zero), .sat(w1_sat)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {out, co, zero, sat}
  logic [W+2:0] exp_q0[$];
  logic [W+2:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_out [2];
  logic         m_co  [2];
  logic         m_sat [2];

  task automatic check(input string tag, input logic [W+2:0] obs, input logic [W+2:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = RV;
      m_co[k]  = 1'b0;
      m_sat[k] = 1'b0;
    end
  endtask

  // Behaviour of one rising edge; k==1 is the saturating instance.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset || clr) begin
        m_out[k] = RV;
        m_co[k]  = 1'b0;
        m_sat[k] = 1'b0;
      end else if (en) begin
        case (mode)
          3'd1: begin m_out[k] = in; m_co[k] = 1'b0; m_sat[k] = 1'b0; end
          3'd2: begin
            m_co[k] = (m_out[k] == 8'hFF);
            if (m_out[k] == 8'hFF && k == 1) m_sat[k] = 1'b1;
            else begin m_out[k] = m_out[k] + 8'd1; m_sat[k] = 1'b0; end
          end
          3'd3: begin
            m_co[k] = (m_out[k] == 8'h00);
            if (m_out[k] == 8'h00 && k == 1) m_sat[k] = 1'b1;
            else begin m_out[k] = m_out[k] - 8'd1; m_sat[k] = 1'b0; end
          end
          3'd4: begin m_co[k] = m_out[k][7]; m_out[k] = {m_out[k][6:0], ser_in};    m_sat[k] = 1'b0; end
          3'd5: begin m_co[k] = m_out[k][0]; m_out[k] = {ser_in, m_out[k][7:1]};    m_sat[k] = 1'b0; end
          3'd6: begin m_co[k] = m_out[k][7]; m_out[k] = {m_out[k][6:0], m_out[k][7]}; m_sat[k] = 1'b0; end
          3'd7: begin m_co[k] = m_out[k][0]; m_out[k] = {m_out[k][0], m_out[k][7:1]}; m_sat[k] = 1'b0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic push_expected();
    exp_q0.push_back({m_out[0], m_co[0], (m_out[0] == 8'h00), m_sat[0]});
    exp_q1.push_back({m_out[1], m_co[1], (m_out[1] == 8'h00), m_sat[1]});
  endtask

  task automatic sb_check(input string tag);
    logic [W+2:0] e;
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue observed empty expected entry", tag);
    end else begin
      e = exp_q0.pop_front();
      check({tag, "_wrap"}, {w0_out, w0_co, w0_zero, w0_sat}, e);
      e = exp_q1.pop_front();
      check({tag, "_sat"}, {w1_out, w1_co, w1_zero, w1_sat}, e);
    end
  endtask

  // driver: apply inputs, predict, clock once, compare 1 time unit after the edge
  task automatic step(input string tag, input logic c, input logic e, input logic [2:0] m,
                      input logic [W-1:0] d, input logic s);
    clr = c; en = e; mode = m; in = d; ser_in = s;
    model_edge();
    push_expected();
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b0; mode = 3'd0; in = '0; ser_in = 1'b0;
    model_reset();
    #1;
    push_expected();
    sb_check("reset_init");
    check("reset_init_const", {w0_out, w0_co, w0_zero, w0_sat}, {8'h5A, 3'b000});

    @(negedge clk);
    reset = 1'b0;
    step("t1_load11", 1'b0, 1'b1, 3'd1, 8'h11, 1'b0);

    // asynchronous reset between edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    push_expected();
    sb_check("t1_async_reset");
    check("t1_async_const", {w1_out, w1_co, w1_zero, w1_sat}, {8'h5A, 3'b000});
    @(negedge clk);
    reset = 1'b0;
    step("t1_load00", 1'b0, 1'b1, 3'd1, 8'h00, 1'b0);
    check("t1_zero", {w0_out, w0_zero}, {8'h00, 1'b1});

    // increment across all-ones
    step("t2_loadFE", 1'b0, 1'b1, 3'd1, 8'hFE, 1'b0);
    step("t2_inc1",   1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    step("t2_inc2",   1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    check("t2_wrap_to0", {w0_out, w0_co, w0_zero}, {8'h00, 2'b11});
    step("t2_inc3",   1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    check("t2_wrap_01", {w0_out, w0_co}, {8'h01, 1'b0});
    check("t3_sat_hi", {w1_out, w1_co, w1_sat}, {8'hFF, 1'b1, 1'b1});

    // decrement across zero
    step("t3_load01", 1'b0, 1'b1, 3'd1, 8'h01, 1'b0);
    step("t3_dec1",   1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    check("t3_sat_dec1", {w1_out, w1_sat}, {8'h00, 1'b0});
    step("t3_dec2",   1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    check("t2_wrap_borrow", {w0_out, w0_co, w0_sat}, {8'hFF, 1'b1, 1'b0});
    check("t3_sat_lo", {w1_out, w1_co, w1_zero, w1_sat}, {8'h00, 3'b111});

    // shifts and rotates
    step("t4_load81", 1'b0, 1'b1, 3'd1, 8'h81, 1'b0);
    step("t4_shl",    1'b0, 1'b1, 3'd4, 8'h00, 1'b0);
    check("t4_shl_const", {w0_out, w0_co}, {8'h02, 1'b1});
    step("t4_shr",    1'b0, 1'b1, 3'd5, 8'h00, 1'b1);
    check("t4_shr_const", {w0_out, w0_co}, {8'h81, 1'b0});
    step("t4_rotr",   1'b0, 1'b1, 3'd7, 8'h00, 1'b0);
    check("t4_rotr_const", {w0_out, w0_co}, {8'hC0, 1'b1});
    step("t4_rotl",   1'b0, 1'b1, 3'd6, 8'h00, 1'b1);
    check("t4_rotl_const", {w1_out, w1_co}, {8'h81, 1'b1});

    // priority: clr over en/mode, en=0 holds, mode 000 holds
    step("t5_load33", 1'b0, 1'b1, 3'd1, 8'h33, 1'b0);
    step("t5_clr",    1'b1, 1'b1, 3'd2, 8'h00, 1'b0);
    check("t5_clr_const", {w0_out, w0_co}, {8'h5A, 1'b0});
    step("t5_en0",    1'b0, 1'b0, 3'd1, 8'hAA, 1'b0);
    check("t5_en0_const", w0_out, {3'b000, 8'h5A});
    step("t5_setco",  1'b0, 1'b1, 3'd4, 8'h00, 1'b0);
    step("t5_hold",   1'b0, 1'b1, 3'd0, 8'hAA, 1'b1);
    check("t5_hold_const", {w0_out, w0_co}, {8'hB4, 1'b0});
    step("t5_en0_co", 1'b0, 1'b0, 3'd5, 8'h00, 1'b0);

    // reset during counting
    step("t6_load00", 1'b0, 1'b1, 3'd1, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) step("t6_inc", 1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    check("t6_at07", w0_out, {3'b000, 8'h07});
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    push_expected();
    sb_check("t6_async");
    step("t6_rst_hold1", 1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    step("t6_rst_hold2", 1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("t6_first_inc", 1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    check("t6_first_inc_const", w1_out, {3'b000, 8'h5B});

    // randomized mix, clr and en=0 occasional
    for (int i = 0; i < 60; i++) begin
      step("rand",
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
